sparse_decoder_vec: RTL and testbench
=====================================

SPARSE_DECODER_VEC -- requirements
Module: sparse_decoder_vec

Interface
REQ-001 The module SHALL have parameter SKIP_W, default 8, meaning the skip field width in bits.
REQ-002 The module SHALL have parameter VALUE_W, default 16, meaning the value field width in bits.
REQ-003 The module SHALL have parameter VEC_LEN, default 64, meaning the vector length; the legal range is 2..65536.
REQ-004 The module SHALL have derived parameter IDX_W = $clog2(VEC_LEN).
REQ-005 mac_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 mac_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 mode_dense_i  input  1  SHALL select the mode: 0 = sparse, 1 = dense zero-fill.
REQ-008 sram_valid_i  input  1  SHALL indicate that an input entry is valid.
REQ-009 sram_ready_o  output  1  SHALL indicate that the decoder accepts an entry this cycle.
REQ-010 sram_skip_i  input  SKIP_W  SHALL carry the count of zeros preceding the entry.
REQ-011 sram_value_i  input  VALUE_W  SHALL carry the nonzero value.
REQ-012 sram_ext_i  input  1  SHALL mark a skip-extension entry, which carries no value.
REQ-013 sram_last_i  input  1  SHALL mark the final value entry of a vector.
REQ-014 decoder_valid_o  output  1  SHALL indicate that an output element is valid.
REQ-015 decoder_ready_i  input  1  SHALL indicate that the consumer accepts the output element.
REQ-016 decoder_index_o  output  IDX_W  SHALL carry the element index.
REQ-017 decoder_value_o  output  VALUE_W  SHALL carry the element value; it SHALL be 0 for fill elements.
REQ-018 decoder_last_o  output  1  SHALL mark the final element of a vector.
REQ-019 err_overflow_o  output  1  SHALL be a sticky index-overflow flag.

Function
REQ-020 Handshakes SHALL follow valid/ready semantics: a transfer occurs when valid and ready are both 1 at a rising edge.
REQ-021 While decoder_valid_o=1 and decoder_ready_i=0, all decoder_* outputs SHALL hold stable.
REQ-022 The output SHALL be a single register stage; sram_ready_o SHALL be 1 only when state=IDLE and (decoder_valid_o=0 or decoder_ready_i=1).
REQ-023 The FSM SHALL have exactly three states: IDLE (accepting), FILL (emitting zeros before a value), and TAIL (emitting zeros after a last entry).
REQ-024 The running index cur SHALL be a counter of IDX_W+1 bits; the target tgt SHALL be computed as cur+skip in max(IDX_W,SKIP_W)+1 bits, with no truncation.
REQ-025 Mode SHALL be latched from mode_dense_i only on accept when cur=0; changes to mode_dense_i mid-vector SHALL be ignored.
REQ-026 Sparse, value entry: the output SHALL be (tgt, value, last) with valid asserted the cycle after accept; then cur <= tgt+1.
REQ-027 Sparse, ext entry: there SHALL be no output; cur <= tgt; sram_last_i SHALL be ignored.
REQ-028 Dense, value entry with skip S>0: the FSM SHALL go to FILL and emit S zero elements at indices cur..tgt-1, then emit the value at tgt, one element per output transfer.
REQ-029 Dense, value entry with skip S=0: the value SHALL be emitted directly, with the same latency as sparse mode.
REQ-030 Dense, ext entry: S zero elements SHALL be emitted, with no value element.
REQ-031 Dense, last value at tgt<VEC_LEN-1: the FSM SHALL go to TAIL and emit zeros for tgt+1..VEC_LEN-1; decoder_last_o SHALL be 1 only on index VEC_LEN-1.
REQ-032 Dense, last value at tgt=VEC_LEN-1: last SHALL be asserted on the value element and TAIL SHALL be skipped.
REQ-033 End of vector (a last transfer completes, in either mode): cur SHALL be set to 0 and mode SHALL be re-latchable.
REQ-034 Overflow, i.e. a value entry with tgt>VEC_LEN-1 or an ext entry with tgt>VEC_LEN: the entry SHALL be accepted and dropped with no output, err_overflow_o SHALL be set to 1, and cur SHALL be set to 0.
REQ-035 err_overflow_o SHALL be cleared only by reset.
REQ-036 Throughput: sparse mode SHALL sustain 1 entry/cycle with decoder_ready_i=1; dense mode SHALL sustain 1 element/cycle.

Reset
REQ-037 While mac_rst_n=0: sram_ready_o=0, decoder_valid_o=0, decoder_index_o=0, decoder_value_o=0, decoder_last_o=0, err_overflow_o=0, cur=0, state=IDLE, mode=sparse.
REQ-038 Reset assertion mid-FILL or mid-TAIL SHALL abort immediately, and the in-flight output SHALL be discarded.
REQ-039 sram_ready_o SHALL be 1 on the first rising edge after mac_rst_n deasserts.

Verification
REQ-040 VEC_LEN=16, sparse, decoder_ready_i=1, entries (skip5,val3),(skip4,val6,last) -> outputs (5,3,last0) then (10,6,last1), each 1 cycle after its accept; the next vector starts at 0.
REQ-041 Dense, entries (skip2,val7),(skip0,val9,last) -> 16 outputs: idx0..3 = 0,0,7,9; idx4..15 = 0; last=1 only at idx15; sram_ready_o=0 during FILL/TAIL.
REQ-042 Sparse, ext(skip6) then (skip1,val2) -> a single output (7,2).
REQ-043 Sparse, cur=10, entry (skip8,val5) -> no output, err_overflow_o=1; then (skip0,val4) -> output (0,4); err_overflow_o stays 1.
REQ-044 Random decoder_ready_i over 200 random entries in both modes -> the output stream matches the golden model, and outputs stay stable while stalled.
REQ-045 Dense, reset pulse during FILL at index 3 -> outputs go to 0 asynchronously; after release, (skip0,val1) -> output (0,1).

Source files
------------

// File: rtl/sparse_decoder_vec.sv
// Expands run-length (skip,value) entries into indexed elements, sparse or dense zero-filled.
// One output register stage; FILL/TAIL emit one element per output transfer while input is held off.
module sparse_decoder_vec #(
  parameter int SKIP_W  = 8,
  parameter int VALUE_W = 16,
  parameter int VEC_LEN = 64,
  localparam int IDX_W  = $clog2(VEC_LEN)
) (
  input  logic               mac_clk,
  input  logic               mac_rst_n,
  input  logic               mode_dense_i,
  input  logic               sram_valid_i,
  output logic               sram_ready_o,
  input  logic [SKIP_W-1:0]  sram_skip_i,
  input  logic [VALUE_W-1:0] sram_value_i,
  input  logic               sram_ext_i,
  input  logic               sram_last_i,
  output logic               decoder_valid_o,
  input  logic               decoder_ready_i,
  output logic [IDX_W-1:0]   decoder_index_o,
  output logic [VALUE_W-1:0] decoder_value_o,
  output logic               decoder_last_o,
  output logic               err_overflow_o
);
  localparam int TW = ((IDX_W > SKIP_W) ? IDX_W : SKIP_W) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(VEC_LEN - 1);
  localparam logic [TW-1:0]  T_LEN  = TW'(VEC_LEN);
  localparam logic [IDX_W:0] C_LAST = (IDX_W+1)'(VEC_LEN - 1);
  localparam logic [IDX_W:0] C_ONE  = (IDX_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, TAIL} state_e;

  state_e             state_q, state_d;
  logic [IDX_W:0]     cur_q, cur_d, ptgt_q, ptgt_d;
  logic [VALUE_W-1:0] pval_q, pval_d, val_q, val_d;
  logic               plast_q, plast_d, pext_q, pext_d, mode_q, mode_d;
  logic               vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               out_free, accept, dense, ovf;
  logic [TW-1:0]      tgt;
  logic [IDX_W:0]     tgt_c, cur_inc, v_tgt;
  logic [VALUE_W-1:0] v_val;
  logic               emit_zero, zero_last, emit_val, v_last, v_dense;

  assign out_free     = !vld_q || decoder_ready_i;
  assign sram_ready_o = mac_rst_n && (state_q == IDLE) && out_free;
  assign accept       = sram_valid_i && sram_ready_o;
  // Mode is taken live only at the start of a vector, otherwise from the latch.
  assign dense        = (cur_q == '0) ? mode_dense_i : mode_q;
  assign tgt          = TW'(cur_q) + TW'(sram_skip_i);
  assign tgt_c        = tgt[IDX_W:0];
  assign cur_inc      = cur_q + C_ONE;
  assign ovf          = sram_ext_i ? (tgt > T_LEN) : (tgt > T_LAST);

  always_comb begin
    state_d = state_q;  cur_d = cur_q;  mode_d = mode_q;  err_d = err_q;
    ptgt_d = ptgt_q;  pval_d = pval_q;  plast_d = plast_q;  pext_d = pext_q;
    vld_d = vld_q && !decoder_ready_i;
    idx_d = idx_q;  val_d = val_q;  last_d = last_q;
    emit_zero = 1'b0;  zero_last = 1'b0;  emit_val = 1'b0;
    v_tgt = tgt_c;  v_val = sram_value_i;  v_last = sram_last_i;  v_dense = dense;
    case (state_q)
      IDLE: if (accept) begin
        if (cur_q == '0) mode_d = mode_dense_i;
        if (ovf) begin
          err_d = 1'b1;
          cur_d = '0;
        end else if (dense && (sram_skip_i != '0)) begin
          emit_zero = 1'b1;
          ptgt_d  = tgt_c;
          pval_d  = sram_value_i;
          plast_d = sram_last_i;
          pext_d  = sram_ext_i;
          state_d = (sram_ext_i && (cur_inc == tgt_c)) ? IDLE : FILL;
        end else if (sram_ext_i) begin
          cur_d = tgt_c;
        end else begin
          emit_val = 1'b1;
        end
      end
      FILL: if (out_free) begin
        if (!pext_q && (cur_q == ptgt_q)) begin
          emit_val = 1'b1;
          v_tgt    = ptgt_q;
          v_val    = pval_q;
          v_last   = plast_q;
          v_dense  = 1'b1;
          state_d  = IDLE;
        end else begin
          emit_zero = 1'b1;
          if (pext_q && (cur_inc == ptgt_q)) state_d = IDLE;
        end
      end
      TAIL: if (out_free) begin
        emit_zero = 1'b1;
        zero_last = (cur_q == C_LAST);
        if (zero_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (emit_zero) begin
      vld_d  = 1'b1;
      idx_d  = cur_q[IDX_W-1:0];
      val_d  = '0;
      last_d = zero_last;
      cur_d  = zero_last ? '0 : cur_inc;
    end
    if (emit_val) begin
      vld_d  = 1'b1;
      idx_d  = v_tgt[IDX_W-1:0];
      val_d  = v_val;
      // Dense vectors always end on the final index; a short one finishes through TAIL.
      last_d = v_last && (!v_dense || (v_tgt == C_LAST));
      cur_d  = last_d ? '0 : (v_tgt + C_ONE);
      if (v_dense && v_last && (v_tgt != C_LAST)) state_d = TAIL;
    end
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q <= IDLE;  cur_q <= '0;  mode_q <= 1'b0;  err_q <= 1'b0;
      ptgt_q <= '0;  pval_q <= '0;  plast_q <= 1'b0;  pext_q <= 1'b0;
      vld_q <= 1'b0;  idx_q <= '0;  val_q <= '0;  last_q <= 1'b0;
    end else begin
      state_q <= state_d;  cur_q <= cur_d;  mode_q <= mode_d;  err_q <= err_d;
      ptgt_q <= ptgt_d;  pval_q <= pval_d;  plast_q <= plast_d;  pext_q <= pext_d;
      vld_q <= vld_d;  idx_q <= idx_d;  val_q <= val_d;  last_q <= last_d;
    end
  end

  assign decoder_valid_o = vld_q;
  assign decoder_index_o = idx_q;
  assign decoder_value_o = val_q;
  assign decoder_last_o  = last_q;
  assign err_overflow_o  = err_q;
endmodule

// File: tb/tb_sparse_decoder_vec.sv
// Scoreboard bench for sparse_decoder_vec: directed scenarios plus randomized entries with random output stalls.
module tb_sparse_decoder_vec;
  localparam int LEN = 16;

  logic        mac_clk = 1'b0;
  logic        mac_rst_n;
  logic        mode_dense_i, sram_valid_i, sram_ready_o, sram_ext_i, sram_last_i;
  logic [7:0]  sram_skip_i;
  logic [15:0] sram_value_i;
  logic        decoder_valid_o, decoder_ready_i, decoder_last_o, err_overflow_o;
  logic [3:0]  decoder_index_o;
  logic [15:0] decoder_value_o;

  typedef struct { int idx; int val; bit last; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int vectors = 0, miscompares = 0;
  int m_cur = 0;
  bit m_dense = 1'b0, m_err = 1'b0;
  bit rdy_rand = 1'b0;
  bit hold_vld = 1'b0, hold_last;
  int hold_idx, hold_val;

  sparse_decoder_vec #(.SKIP_W(8), .VALUE_W(16), .VEC_LEN(LEN)) dut (
    .mac_clk(mac_clk), .mac_rst_n(mac_rst_n), .mode_dense_i(mode_dense_i),
    .sram_valid_i(sram_valid_i), .sram_ready_o(sram_ready_o), .sram_skip_i(sram_skip_i),
    .sram_value_i(sram_value_i), .sram_ext_i(sram_ext_i), .sram_last_i(sram_last_i),
    .decoder_valid_o(decoder_valid_o), .decoder_ready_i(decoder_ready_i),
    .decoder_index_o(decoder_index_o), .decoder_value_o(decoder_value_o),
    .decoder_last_o(decoder_last_o), .err_overflow_o(err_overflow_o));

  always #5 mac_clk = ~mac_clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int val, input bit last);
    exp_t e;
    e.idx = idx; e.val = val; e.last = last;
    sb.push_back(e);
  endtask

  // Reference: whole-entry expansion into the element list it should produce.
  task automatic model_entry(input bit dense_in, input int skip, input int val, input bit ext, input bit last);
    int tgt;
    if (m_cur == 0) m_dense = dense_in;
    tgt = m_cur + skip;
    if ((ext && tgt > LEN) || (!ext && tgt > LEN - 1)) begin
      m_err = 1'b1;
      m_cur = 0;
      return;
    end
    if (m_dense) for (int i = m_cur; i < tgt; i++) push(i, 0, 1'b0);
    if (ext) begin
      m_cur = tgt;
    end else if (!m_dense) begin
      push(tgt, val, last);
      m_cur = last ? 0 : tgt + 1;
    end else if (last) begin
      push(tgt, val, tgt == LEN - 1);
      for (int i = tgt + 1; i < LEN; i++) push(i, 0, i == LEN - 1);
      m_cur = 0;
    end else begin
      push(tgt, val, 1'b0);
      m_cur = tgt + 1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still driven.
  task automatic send(input bit dense, input int skip, input int val, input bit ext, input bit last);
    bit got = 1'b0;
    mode_dense_i = dense; sram_skip_i = 8'(skip); sram_value_i = 16'(val);
    sram_ext_i = ext; sram_last_i = last; sram_valid_i = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      #4;
      if (sram_ready_o) begin
        got = 1'b1;
        model_entry(dense, skip, val, ext, last);
      end
      @(negedge mac_clk);
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: entry skip %0d value %0d never accepted, expected accept", skip, val);
    end
  endtask

  task automatic expect_next(input int idx, input int val, input bit last);
    sram_valid_i = 1'b0;
    #4;
    check("lat_valid", int'(decoder_valid_o), 1);
    check("lat_index", int'(decoder_index_o), idx);
    check("lat_value", int'(decoder_value_o), val);
    check("lat_last", int'(decoder_last_o), int'(last));
    @(negedge mac_clk);
  endtask

  task automatic drain(input int budget);
    sram_valid_i = 1'b0;
    for (int n = 0; n < budget && !(sb.size() == 0 && !decoder_valid_o); n++) @(negedge mac_clk);
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    decoder_ready_i = 1'b1;
    forever begin
      @(negedge mac_clk);
      decoder_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    forever begin
      @(negedge mac_clk);
      #4;
      if (!mac_rst_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("stall_valid", int'(decoder_valid_o), 1);
          check("stall_index", int'(decoder_index_o), hold_idx);
          check("stall_value", int'(decoder_value_o), hold_val);
          check("stall_last", int'(decoder_last_o), int'(hold_last));
        end
        if (decoder_valid_o && decoder_ready_i) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_output: index %0d value %0d, expected no output",
                     decoder_index_o, decoder_value_o);
          end else begin
            mon_e = sb.pop_front();
            check("out_index", int'(decoder_index_o), mon_e.idx);
            check("out_value", int'(decoder_value_o), mon_e.val);
            check("out_last", int'(decoder_last_o), int'(mon_e.last));
          end
          hold_vld = 1'b0;
        end else if (decoder_valid_o) begin
          hold_vld = 1'b1; hold_idx = int'(decoder_index_o);
          hold_val = int'(decoder_value_o); hold_last = decoder_last_o;
        end else begin
          hold_vld = 1'b0;
        end
      end
    end
  end

  initial begin
    bit found;
    mac_rst_n = 1'b0; sram_valid_i = 1'b0; mode_dense_i = 1'b0;
    sram_skip_i = '0; sram_value_i = '0; sram_ext_i = 1'b0; sram_last_i = 1'b0;
    #3;
    check("rst_ready", int'(sram_ready_o), 0);
    check("rst_valid", int'(decoder_valid_o), 0);
    check("rst_index", int'(decoder_index_o), 0);
    check("rst_value", int'(decoder_value_o), 0);
    check("rst_last", int'(decoder_last_o), 0);
    check("rst_err", int'(err_overflow_o), 0);
    @(negedge mac_clk); @(negedge mac_clk);
    mac_rst_n = 1'b1;
    #4 check("ready_after_rst", int'(sram_ready_o), 1);
    @(negedge mac_clk);

    // Sparse vector, one-cycle latency per element.
    send(1'b0, 5, 3, 1'b0, 1'b0); expect_next(5, 3, 1'b0);
    send(1'b0, 4, 6, 1'b0, 1'b1); expect_next(10, 6, 1'b1);
    drain(20);

    // Dense vector with fill and tail; input held off during the tail.
    send(1'b1, 2, 7, 1'b0, 1'b0);
    send(1'b1, 0, 9, 1'b0, 1'b1);
    sram_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4 check("tail_ready_low", int'(sram_ready_o), 0);
      @(negedge mac_clk);
    end
    drain(40);

    // Skip extension then value.
    send(1'b0, 6, 0, 1'b1, 1'b0);
    send(1'b0, 1, 2, 1'b0, 1'b1);
    drain(20);

    // Overflow drops the entry and sets the sticky flag.
    send(1'b0, 9, 1, 1'b0, 1'b0);
    send(1'b0, 8, 5, 1'b0, 1'b0);
    drain(20);
    check("err_set", int'(err_overflow_o), 1);
    send(1'b0, 0, 4, 1'b0, 1'b1); expect_next(0, 4, 1'b1);
    drain(20);
    check("err_sticky", int'(err_overflow_o), 1);

    // Reset while filling.
    send(1'b1, 10, 1, 1'b0, 1'b0);
    sram_valid_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      #4;
      if (decoder_valid_o && decoder_index_o == 4'd3) found = 1'b1;
      @(negedge mac_clk);
    end
    check("fill_reached_idx3", int'(found), 1);
    #1;
    mac_rst_n = 1'b0;
    sb.delete(); m_cur = 0; m_dense = 1'b0; m_err = 1'b0;
    #1;
    check("arst_valid", int'(decoder_valid_o), 0);
    check("arst_index", int'(decoder_index_o), 0);
    check("arst_value", int'(decoder_value_o), 0);
    check("arst_ready", int'(sram_ready_o), 0);
    check("arst_err", int'(err_overflow_o), 0);
    @(negedge mac_clk); @(negedge mac_clk);
    mac_rst_n = 1'b1;
    #4 check("ready_after_arst", int'(sram_ready_o), 1);
    @(negedge mac_clk);
    send(1'b1, 0, 1, 1'b0, 1'b0); expect_next(0, 1, 1'b0);
    drain(20);

    // Randomized entries in both modes with random output stalls.
    rdy_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int skip;
      if ($urandom_range(0, 3) == 0) begin
        sram_valid_i = 1'b0;
        @(negedge mac_clk);
      end
      skip = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(0, 4));
      send(bit'($urandom_range(0, 1)), skip, int'($urandom_range(1, 65535)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end
    sram_valid_i = 1'b0;
    rdy_rand = 1'b0;
    drain(2000);
    check("err_final", int'(err_overflow_o), int'(m_err));
    repeat (3) @(negedge mac_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
